jpeg_block_seq: RTL
===================

Name: jpeg_block_seq

Overview:
Sequencer for the 64-symbol combinational JPEG block decoder (decoder_full).
- Accepts 14-bit encoded symbols one per cycle over a valid/ready stream and assembles them into the decoder's 896-bit input.
- Holds that input stable for a configurable settle window (a multicycle path), then captures the 512-bit packed result.
- Streams the result out as 64 bytes over a valid/ready stream, with a block counter and length-error reporting.

Parameters:
- SYM_W, 14, width of one encoded symbol.
- N_SYM, 64, symbols per block (also bytes per output block).
- BYTE_W, 8, output byte width.
- DEC_LAT, 2, cycles dec_data_in is held before capture; legal range is ≥1.
- CNT_W, 16, width of the block counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  symbol valid.
- in_ready  out  1  symbol accepted when in_valid&&in_ready.
- in_sym  in  SYM_W  encoded symbol.
- in_last  in  1  marks final symbol of a block.
- dec_data_in  out  SYM_W*N_SYM  to decoder; symbol k at [SYM_W*k +: SYM_W].
- dec_data_out  in  BYTE_W*N_SYM  packed decoder result, MSB-justified.
- out_valid  out  1  byte valid.
- out_ready  in  1  byte consumed when out_valid&&out_ready.
- out_byte  out  BYTE_W  output byte.
- out_last  out  1  high with byte 63 of a block.
- busy  out  1  high in SETTLE or DRAIN.
- blk_cnt  out  CNT_W  completed blocks; wraps.
- err_len  out  1  one-cycle pulse on block length mismatch.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. All flops clear on assertion.
- Reset values: state=LOAD, sym_cnt=0, settle_cnt=0, byte_idx=0, sym_buf=0 (so dec_data_in=0), out_buf=0, in_ready=1, out_valid=0, out_byte=0, out_last=0, busy=0, blk_cnt=0, err_len=0.
- State LOAD:
  - in_ready=1.
  - On accept, sym_buf[SYM_W*sym_cnt +: SYM_W] <= in_sym and sym_cnt++.
  - in_last accepted with sym_cnt<63: err_len pulses, sym_cnt<=0, the partial block is discarded, and the state stays LOAD.
  - Accept at sym_cnt==63: go to SETTLE and set sym_cnt<=0. If in_last==0 on that accept, err_len pulses but the block still proceeds.
- State SETTLE:
  - in_ready=0, busy=1; sym_buf is frozen, so dec_data_in is stable.
  - settle_cnt counts 0..DEC_LAT-1. In the cycle settle_cnt==DEC_LAT-1: out_buf <= dec_data_out, settle_cnt<=0, go to DRAIN.
  - Latency: the first out_valid appears DEC_LAT+1 cycles after the 64th accept.
- State DRAIN:
  - out_valid=1, busy=1, in_ready=0.
  - out_byte=out_buf[BYTE_W*N_SYM-1 -: BYTE_W], i.e. byte 0 is the MSB byte.
  - out_last = (byte_idx==63).
  - On handshake: out_buf <<= BYTE_W, byte_idx++.
  - Handshake at byte_idx==63: byte_idx<=0, blk_cnt++ (modulo 2^CNT_W), go to LOAD.
  - out_ready low: out_byte, out_valid and out_last hold unchanged (no drop, no duplicate).
- Outputs are driven combinationally from state and registers; no input-to-output combinational path.
- The first symbol of the next block can be accepted the cycle after the last byte handshake. There is no overlap of LOAD with DRAIN.
- Reset mid-operation: asynchronously aborts to reset values. A partial block or partial drain is lost; blk_cnt=0.
- dec_data_out is sampled only in the capture cycle and ignored otherwise.

Decomposition:
- Shared package holds:
  - state enum {LOAD, SETTLE, DRAIN};
  - N_SYM, SYM_W and BYTE_W constants;
  - the 896/512 bus width localparams reused by decoder_full.
- One natural sub-module, jpeg_byte_drain: the out_buf shift register, byte_idx, and valid/ready/last logic, with a load strobe input and a done output. The top keeps the load/settle FSM and the counters.

Test Plan:
- Basic block: 64 symbols with in_sym=k, in_last on the 64th, dec_data_out stub = {8'h00,8'h01,...,8'h3F}.
  - Expected: dec_data_in[14k+:14]==k; first out_valid DEC_LAT+1 cycles after the last accept.
  - Bytes 0x00..0x3F in order; out_last only on 0x3F; blk_cnt=1.
- Backpressure: out_ready toggles 1,0,0,1 randomly.
  - Expected: exactly 64 bytes, identical sequence, out_byte stable while stalled, in_ready=0 throughout DRAIN.
- Early in_last: in_last on the 10th symbol.
  - Expected: err_len one-cycle pulse, no SETTLE, no output bytes, blk_cnt unchanged; the next full block decodes correctly.
- Missing in_last: 64 symbols with in_last=0.
  - Expected: err_len pulse on the 64th accept; block drains normally; blk_cnt increments.
- Reset mid-drain: assert rst_n=0 asynchronously at byte 20.
  - Expected: out_valid=0 immediately, blk_cnt=0, in_ready=1 after release.
- Wrap: preload or run so blk_cnt=16'hFFFF, then complete a block.
  - Expected: blk_cnt=16'h0000.
  - With DEC_LAT=1: capture occurs one cycle after the last accept.

Source files
------------

// File: rtl/jpeg_block_seq_pkg.sv
// rtl/jpeg_block_seq_pkg.sv - shared constants and state type for the JPEG block sequencer
package jpeg_block_seq_pkg;
    localparam int SYM_W     = 14;
    localparam int N_SYM     = 64;
    localparam int BYTE_W    = 8;
    localparam int DEC_IN_W  = SYM_W * N_SYM;   // 896-bit decoder input bus
    localparam int DEC_OUT_W = BYTE_W * N_SYM;  // 512-bit decoder result bus
    localparam int IDX_W     = $clog2(N_SYM);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;
endpackage

// File: rtl/jpeg_block_seq_if.sv
// rtl/jpeg_block_seq_if.sv - symbol input stream and byte output stream of the block sequencer
interface jpeg_block_seq_if;
    import jpeg_block_seq_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [SYM_W-1:0]  in_sym;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [BYTE_W-1:0] out_byte;
    logic              out_last;

    modport master (
        output in_valid, in_sym, in_last, out_ready,
        input  in_ready, out_valid, out_byte, out_last
    );

    modport slave (
        input  in_valid, in_sym, in_last, out_ready,
        output in_ready, out_valid, out_byte, out_last
    );
endinterface

// File: rtl/jpeg_byte_drain.sv
// rtl/jpeg_byte_drain.sv - shifts a captured 512-bit result out MSB byte first over valid/ready
module jpeg_byte_drain
    import jpeg_block_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [DEC_OUT_W-1:0] load_data_i,
    input  logic                 out_ready_i,
    output logic                 out_valid_o,
    output logic [BYTE_W-1:0]    out_byte_o,
    output logic                 out_last_o,
    output logic                 done_o
);
    logic [DEC_OUT_W-1:0] out_buf_q, out_buf_d;
    logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
    logic                 valid_q, valid_d;
    logic                 last_byte;
    logic                 hs;

    assign last_byte = (byte_idx_q == IDX_W'(N_SYM - 1));
    assign hs        = valid_q && out_ready_i;

    // Load a fresh result, or advance one byte per handshake; a stall leaves everything untouched.
    always_comb begin
        out_buf_d  = out_buf_q;
        byte_idx_d = byte_idx_q;
        valid_d    = valid_q;
        if (load_i) begin
            out_buf_d  = load_data_i;
            byte_idx_d = '0;
            valid_d    = 1'b1;
        end else if (hs) begin
            out_buf_d  = out_buf_q << BYTE_W;
            byte_idx_d = last_byte ? '0 : byte_idx_q + IDX_W'(1);
            if (last_byte) begin
                valid_d = 1'b0;
            end
        end
    end

    // Drain state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_buf_q  <= '0;
            byte_idx_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            out_buf_q  <= out_buf_d;
            byte_idx_q <= byte_idx_d;
            valid_q    <= valid_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_byte_o  = out_buf_q[DEC_OUT_W-1 -: BYTE_W];
    assign out_last_o  = valid_q && last_byte;
    assign done_o      = hs && last_byte;
endmodule

// File: rtl/jpeg_block_seq.sv
// rtl/jpeg_block_seq.sv - assembles 64 symbols, waits out the decoder settle window, drains 64 bytes
module jpeg_block_seq
    import jpeg_block_seq_pkg::*;
#(
    parameter int DEC_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    jpeg_block_seq_if.slave      bus,
    output logic [DEC_IN_W-1:0]  dec_data_in,
    input  logic [DEC_OUT_W-1:0] dec_data_out,
    output logic                 busy,
    output logic [CNT_W-1:0]     blk_cnt,
    output logic                 err_len
);
    localparam int SC_W = (DEC_LAT > 1) ? $clog2(DEC_LAT) : 1;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     sym_cnt_q, sym_cnt_d;
    logic [SC_W-1:0]      settle_cnt_q, settle_cnt_d;
    logic [DEC_IN_W-1:0]  sym_buf_q, sym_buf_d;
    logic [CNT_W-1:0]     blk_cnt_q, blk_cnt_d;
    logic                 err_len_q, err_len_d;
    logic                 accept;
    logic                 load;
    logic                 drain_done;

    assign accept = bus.in_valid && (state_q == ST_LOAD);

    // Next-state logic: symbol assembly, settle countdown, capture strobe and block counting.
    always_comb begin
        state_d      = state_q;
        sym_cnt_d    = sym_cnt_q;
        settle_cnt_d = settle_cnt_q;
        sym_buf_d    = sym_buf_q;
        blk_cnt_d    = blk_cnt_q;
        err_len_d    = 1'b0;
        load         = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    sym_buf_d[SYM_W*sym_cnt_q +: SYM_W] = bus.in_sym;
                    if (sym_cnt_q == IDX_W'(N_SYM - 1)) begin
                        // A full block proceeds even without in_last; the mismatch is only flagged.
                        sym_cnt_d = '0;
                        err_len_d = !bus.in_last;
                        state_d   = ST_SETTLE;
                    end else if (bus.in_last) begin
                        // Short block: flag it and start over without decoding.
                        sym_cnt_d = '0;
                        err_len_d = 1'b1;
                    end else begin
                        sym_cnt_d = sym_cnt_q + IDX_W'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SC_W'(DEC_LAT - 1)) begin
                    settle_cnt_d = '0;
                    load         = 1'b1;
                    state_d      = ST_DRAIN;
                end else begin
                    settle_cnt_d = settle_cnt_q + SC_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    blk_cnt_d = blk_cnt_q + CNT_W'(1);
                    state_d   = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            sym_cnt_q    <= '0;
            settle_cnt_q <= '0;
            sym_buf_q    <= '0;
            blk_cnt_q    <= '0;
            err_len_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sym_cnt_q    <= sym_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            sym_buf_q    <= sym_buf_d;
            blk_cnt_q    <= blk_cnt_d;
            err_len_q    <= err_len_d;
        end
    end

    jpeg_byte_drain u_drain (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .load_data_i (dec_data_out),
        .out_ready_i (bus.out_ready),
        .out_valid_o (bus.out_valid),
        .out_byte_o  (bus.out_byte),
        .out_last_o  (bus.out_last),
        .done_o      (drain_done)
    );

    assign bus.in_ready = (state_q == ST_LOAD);
    assign busy         = (state_q != ST_LOAD);
    assign dec_data_in  = sym_buf_q;
    assign blk_cnt      = blk_cnt_q;
    assign err_len      = err_len_q;
endmodule
